l1a_bxn_capture: RTL and testbench

- Downstream consumer of the BXN/TTC synchroniser outputs.
- On every accepted L1A, stamps the current bunch-crossing number and the running L1A event number into a small first-word-fall-through (FWFT) FIFO, read by the DAQ readout builder for event headers.
- Honours fmm_trig_stop (L1A gating) and l1a_cnt_reset (event-number reset with FIFO flush).

---
 rtl/l1a_bxn_capture_pkg.sv | 15 +
 rtl/l1a_bxn_capture_sync_fwft_fifo.sv | 66 ++++++
 rtl/l1a_bxn_capture.sv | 71 +++++++
 tb/tb_l1a_bxn_capture.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/l1a_bxn_capture_pkg.sv
// rtl/l1a_bxn_capture_pkg.sv - shared widths, LHC orbit constants and event-stamp record
package l1a_bxn_capture_pkg;

    localparam int LHC_CYCLE_FULL  = 3564;
    localparam int LHC_CYCLE_SHORT = 924;

    localparam int DEF_L1A_CNT_W = 24;
    localparam int DEF_BXN_W     = 12;

    typedef struct packed {
        logic [DEF_L1A_CNT_W-1:0] l1a_num;
        logic [DEF_BXN_W-1:0]     bxn;
    } evt_stamp_t;

endpackage

// File: rtl/l1a_bxn_capture_sync_fwft_fifo.sv
// rtl/l1a_bxn_capture_sync_fwft_fifo.sv - single-clock first-word-fall-through FIFO with flush
module sync_fwft_fifo #(
    parameter int DW = 36,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rd_ptr_nxt;
    logic          pop_ok;
    logic          push_ok;

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(1);

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // rdata is a registered copy of the head so it can hold its last value once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_nxt;
                if (count > (AW+1)'(1)) begin
                    rdata <= mem[rd_ptr_nxt[AW-1:0]];
                end else if (push_ok) begin
                    rdata <= wdata;
                end
            end else if (empty && push_ok) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/l1a_bxn_capture.sv
// rtl/l1a_bxn_capture.sv - stamps BXN and L1A event number into a FWFT FIFO on each accepted L1A
module l1a_bxn_capture
    import l1a_bxn_capture_pkg::*;
#(
    parameter int L1A_CNT_W = DEF_L1A_CNT_W,
    parameter int BXN_W     = DEF_BXN_W,
    parameter int FIFO_AW   = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       hard_rst,
    input  logic                       l1a,
    input  logic [BXN_W-1:0]           bxn_counter,
    input  logic                       l1a_cnt_reset,
    input  logic                       fmm_trig_stop,
    input  logic                       rd_en,
    output logic [L1A_CNT_W+BXN_W-1:0] rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [FIFO_AW:0]           entry_cnt,
    output logic [L1A_CNT_W-1:0]       l1a_cnt,
    output logic                       overflow,
    output logic [OVF_CNT_W-1:0]       ovf_cnt
);

    logic acc;
    logic drop;

    assign acc  = l1a && !fmm_trig_stop && !l1a_cnt_reset;
    // full implies non-empty, so a same-cycle rd_en always frees a slot
    assign drop = acc && full && !rd_en;

    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            l1a_cnt  <= '0;
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else if (l1a_cnt_reset) begin
            l1a_cnt  <= '0;
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            if (acc) begin
                l1a_cnt <= l1a_cnt + L1A_CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_cnt != '1) begin
                    ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
                end
            end
        end
    end

    sync_fwft_fifo #(
        .DW (L1A_CNT_W + BXN_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (hard_rst),
        .flush (l1a_cnt_reset),
        .push  (acc),
        .pop   (rd_en),
        .wdata ({l1a_cnt, bxn_counter}),
        .rdata (rd_data),
        .empty (empty),
        .full  (full),
        .count (entry_cnt)
    );

endmodule

// File: tb/tb_l1a_bxn_capture.sv
// tb/tb_l1a_bxn_capture.sv - scoreboard bench for l1a_bxn_capture
module tb_l1a_bxn_capture;
    import l1a_bxn_capture_pkg::*;

    logic        clk = 1'b0;
    logic        hard_rst;
    logic        l1a;
    logic [11:0] bxn_counter;
    logic        l1a_cnt_reset;
    logic        fmm_trig_stop;
    logic        rd_en;
    logic [35:0] rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  entry_cnt;
    logic [23:0] l1a_cnt;
    logic        overflow;
    logic [7:0]  ovf_cnt;

    int          checks = 0;
    int          errors = 0;
    evt_stamp_t  sb[$];
    int          m_cnt;
    logic [23:0] m_l1a;

    l1a_bxn_capture dut (
        .clk           (clk),
        .hard_rst      (hard_rst),
        .l1a           (l1a),
        .bxn_counter   (bxn_counter),
        .l1a_cnt_reset (l1a_cnt_reset),
        .fmm_trig_stop (fmm_trig_stop),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .full          (full),
        .entry_cnt     (entry_cnt),
        .l1a_cnt       (l1a_cnt),
        .overflow      (overflow),
        .ovf_cnt       (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        evt_stamp_t e;
        if (hard_rst && !l1a_cnt_reset && rd_en && !empty) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no entry", rd_data);
            end else begin
                e = sb.pop_front();
                chk("pop_data", 64'(rd_data), 64'(e));
            end
        end
    end

    task automatic cyc(input logic l, input logic rd, input logic clr, input logic stop);
        logic pop;
        @(posedge clk);
        #1;
        bxn_counter   = (bxn_counter == 12'(LHC_CYCLE_FULL - 1)) ? 12'd0 : bxn_counter + 12'd1;
        l1a           = l;
        rd_en         = rd;
        l1a_cnt_reset = clr;
        fmm_trig_stop = stop;
        pop = rd && (m_cnt > 0);
        if (clr) begin
            sb.delete();
            m_cnt = 0;
            m_l1a = '0;
        end else if (l && !stop) begin
            if (m_cnt < 16 || pop) begin
                sb.push_back({m_l1a, bxn_counter});
                if (!pop) m_cnt++;
            end
            m_l1a = m_l1a + 24'd1;
        end else if (pop) begin
            m_cnt--;
        end
    endtask

    task automatic idle_until(input int t);
        while (bxn_counter != 12'(t - 1)) cyc(0, 0, 0, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"},     64'(empty),     64'd1);
        chk({tag, "_full"},      64'(full),      64'd0);
        chk({tag, "_entry_cnt"}, 64'(entry_cnt), 64'd0);
        chk({tag, "_l1a_cnt"},   64'(l1a_cnt),   64'd0);
        chk({tag, "_overflow"},  64'(overflow),  64'd0);
        chk({tag, "_ovf_cnt"},   64'(ovf_cnt),   64'd0);
        chk({tag, "_rd_data"},   64'(rd_data),   64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        hard_rst = 1'b0;
        l1a = 1'b0; rd_en = 1'b0; l1a_cnt_reset = 1'b0; fmm_trig_stop = 1'b0;
        bxn_counter = 12'd0;
        m_cnt = 0;
        m_l1a = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        hard_rst = 1'b1;

        // two L1As stamped at bxn 100 and 205
        idle_until(100);
        cyc(1, 0, 0, 0);
        chk("t1_empty_before_edge", 64'(empty), 64'd1);
        cyc(0, 0, 0, 0);
        chk("t1_empty_after", 64'(empty), 64'd0);
        chk("t1_head", 64'(rd_data), {28'd0, 24'd0, 12'd100});
        idle_until(205);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t1_l1a_cnt", 64'(l1a_cnt), 64'd2);
        chk("t1_entry_cnt", 64'(entry_cnt), 64'd2);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t1_drained", 64'(empty), 64'd1);

        // trigger stop gates L1As
        repeat (5) cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("t2_entry_cnt", 64'(entry_cnt), 64'd0);
        chk("t2_l1a_cnt", 64'(l1a_cnt), 64'd2);
        chk("t2_overflow", 64'(overflow), 64'd0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t2_num", 64'(rd_data[35:12]), 64'd0);
        cyc(0, 1, 0, 0);

        // fill to 16 then push+pop while full
        cyc(0, 0, 1, 0);
        repeat (16) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t4_full", 64'(full), 64'd1);
        chk("t4_entry_cnt", 64'(entry_cnt), 64'd16);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t4_entry_cnt_after", 64'(entry_cnt), 64'd16);
        chk("t4_full_after", 64'(full), 64'd1);
        chk("t4_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("t4_l1a_cnt", 64'(l1a_cnt), 64'd17);
        repeat (16) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t4_drained", 64'(empty), 64'd1);

        // 18 L1As into 16 slots
        cyc(0, 0, 1, 0);
        repeat (18) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_entry_cnt", 64'(entry_cnt), 64'd16);
        chk("t3_ovf_cnt", 64'(ovf_cnt), 64'd2);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_l1a_cnt", 64'(l1a_cnt), 64'd18);
        repeat (16) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t3_empty", 64'(empty), 64'd1);
        chk("t3_ovf_sticky", 64'(ovf_cnt), 64'd2);

        // event-number reset beats simultaneous L1A and read
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 0, 0);
        chk("t5_empty", 64'(empty), 64'd1);
        chk("t5_entry_cnt", 64'(entry_cnt), 64'd0);
        chk("t5_l1a_cnt", 64'(l1a_cnt), 64'd0);
        chk("t5_overflow", 64'(overflow), 64'd0);
        chk("t5_ovf_cnt", 64'(ovf_cnt), 64'd0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t5_num", 64'(rd_data[35:12]), 64'd0);
        cyc(0, 1, 0, 0);

        // asynchronous hard reset mid-stream
        repeat (7) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t6_entry_cnt", 64'(entry_cnt), 64'd7);
        #2;
        hard_rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_l1a = '0;
        #1;
        chk_reset_state("t6_async");
        @(posedge clk);
        #1;
        hard_rst = 1'b1;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk_reset_state("t6_after");

        chk("sb_leftover", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
